text_console_writer: RTL and testbench
======================================

// Module: text_console_writer
// PURPOSE
// - CPU/UART-side producer for the 80x30 text-mode character buffer scanned out by the VGA pipeline.
// - Accepts a byte stream over a valid/ready handshake and writes it into the buffer's shared CPU write/read port.
// - Keeps a hardware cursor and interprets control codes: CR, LF, BS and FF.
// - On line overflow past the last row it scrolls the screen up one row: it reads each character back and rewrites it one row higher.
// PARAMETERS
// COLS    80  characters per row
// ROWS    30  rows per screen
// ADDR_W  12  char buffer address width; ROWS*COLS <= 2**ADDR_W
// PORTS
// clk                   in   1       system clock
// reset                 in   1       synchronous, active-high
// ch_valid              in   1       ch_data valid
// ch_data               in   8       character/control byte
// ch_ready              out  1       block can accept a byte (1 in IDLE only)
// char_write_read_addr  out  ADDR_W  buffer CPU-port address (registered)
// char_write_data       out  8       buffer write data (registered)
// char_write_enable     out  1       buffer write strobe (registered)
// char_read_enable      out  1       buffer read strobe (registered)
// r_data_vga_cpu        in   8       buffer read data; valid the cycle after char_read_enable
// cursor_x              out  7       current column, 0..COLS-1
// cursor_y              out  5       current row, 0..ROWS-1
// busy                  out  1       ~ch_ready
// BEHAVIOUR
// - Reset state:
//   - state=IDLE; cursor_x=0, cursor_y=0.
//   - All char_* outputs 0; ch_ready=1 and busy=0 from the first cycle after reset.
// - Handshake: a byte is accepted when ch_valid && ch_ready; ch_valid is ignored otherwise.
//   Producer holds ch_data stable until accepted.
// - Address: addr = cursor_y*COLS + cursor_x, computed in ADDR_W bits.
// - States: IDLE, PUT, SCR_RD, SCR_WR, SCR_FILL, CLR.
// - Printable 0x20..0x7E, accepted at cycle N:
//   - PUT at N+1 with we=1, addr=cursor position, data=byte.
//   - Cursor advances at N+1; state returns to IDLE, so ch_ready=1 at N+2.
//   - Throughput is 1 byte per 2 cycles.
// - Column wrap: a printable at cursor_x==COLS-1 is written first, then cursor_x=0 and the LF rule applies.
// - LF 0x0A: cursor_x=0.
//   - If cursor_y<ROWS-1: cursor_y++ and no write cycle (ready again at N+1).
//   - If cursor_y==ROWS-1: enter scroll; cursor_y stays ROWS-1.
// - CR 0x0D: cursor_x=0, no write.
// - BS 0x08:
//   - If cursor_x>0: cursor_x--, then PUT of 0x20 at the new position.
//   - If cursor_x==0: no-op; the cursor does not move to the previous line.
// - FF 0x0C: CLR writes 0x20 to addr 0..ROWS*COLS-1 ascending, one write per cycle.
//   Cursor is set to (0,0) on entry.
// - Other bytes: accepted and discarded, ready again at N+1.
// - Scroll, for a = COLS .. ROWS*COLS-1 ascending:
//   - SCR_RD: re=1, addr=a.
//   - SCR_WR: we=1, addr=a-COLS, data=r_data_vga_cpu.
//   - Then SCR_FILL writes 0x20 to the last row, (ROWS-1)*COLS .. ROWS*COLS-1.
//   - Total 2*(ROWS-1)*COLS + COLS cycles (4720 at defaults), then IDLE.
// - re and we are never both 1 in the same cycle; both are 0 in IDLE.
// - Reset mid-operation (PUT, scroll or clear):
//   - Aborts next edge; outputs return to reset values.
//   - Buffer contents are left partially updated; no recovery is attempted.
// - The VGA side keeps reading the buffer during scroll and clear; transient tearing is accepted.
// TESTING
// - Reset, send 0x41 -> one cycle later we=1, addr=0, data=0x41; cursor (1,0); ch_ready back 2 cycles after accept.
// - 80x 0x42 then 0x43 -> 0x43 written at addr 80; cursor (1,1); no scroll activity.
// - Preload row r with 0x30+r, cursor (0,29), send LF:
//   -> addr 0 holds 0x31 and addr 2240 holds 0x4D; addrs 2320..2399 hold 0x20; busy for 4720 cycles; cursor (0,29).
// - Send FF from cursor (17,12) -> 2400 consecutive writes of 0x20 to addrs 0..2399; cursor (0,0).
// - Cursor (5,3), send BS -> write 0x20 at addr 244, cursor (4,3); at (0,3) BS -> no write, cursor unchanged.
// - Assert reset 100 cycles into a scroll -> next cycle we=re=0, cursor (0,0), ch_ready=1.

Source files
------------

// File: rtl/text_console_writer.sv
// text_console_writer
// Byte-stream producer for the 80x30 text-mode character buffer. Accepts
// characters over a valid/ready handshake, keeps a hardware cursor,
// interprets CR/LF/BS/FF and scrolls the screen up one row on overflow
// by reading each character back and rewriting it one row higher.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   ch_valid, ch_data     incoming byte, taken when ch_valid && ch_ready
//   ch_ready, busy        ready only in IDLE; busy = ~ch_ready
//   char_write_read_addr  buffer CPU-port address
//   char_write_data       buffer write data
//   char_write_enable     buffer write strobe
//   char_read_enable      buffer read strobe
//   r_data_vga_cpu        buffer read data, valid the cycle after a read
//   cursor_x, cursor_y    current cursor column / row
//
// state    | meaning
// IDLE     | waiting for a byte, only state with ch_ready=1
// PUT      | single character write at the captured cursor address
// SCR_RD   | scroll: read character at ptr
// SCR_WR   | scroll: write that character at ptr-COLS
// SCR_FILL | scroll: blank the last row
// CLR      | form feed: blank the whole screen
module text_console_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ch_valid,
    input  logic [7:0]        ch_data,
    output logic              ch_ready,
    output logic [ADDR_W-1:0] char_write_read_addr,
    output logic [7:0]        char_write_data,
    output logic              char_write_enable,
    output logic              char_read_enable,
    input  logic [7:0]        r_data_vga_cpu,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, PUT, SCR_RD, SCR_WR, SCR_FILL, CLR
    } state_t;

    localparam logic [6:0]        X_LAST = 7'(COLS - 1);
    localparam logic [4:0]        Y_LAST = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] FILL_A = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [7:0]        SPACE  = 8'h20;

    state_t            state_q, state_d;
    logic [6:0]        x_q, x_d;
    logic [4:0]        y_q, y_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              pend_q, pend_d;   // wrap on last row: scroll after the PUT
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [ADDR_W-1:0] cur_addr;

    assign cur_addr = ADDR_W'(y_q) * COLS_A + ADDR_W'(x_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ptr_q   <= '0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        addr_d  = '0;
        wdata_d = '0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ch_valid) begin
                    if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
                        state_d = PUT;
                        we_d    = 1'b1;
                        addr_d  = cur_addr;
                        wdata_d = ch_data;
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q == Y_LAST) pend_d = 1'b1;
                            else               y_d    = y_q + 5'd1;
                        end else begin
                            x_d = x_q + 7'd1;
                        end
                    end else begin
                        case (ch_data)
                            8'h0A: begin
                                x_d = '0;
                                if (y_q == Y_LAST) begin
                                    state_d = SCR_RD;
                                    ptr_d   = COLS_A;
                                    re_d    = 1'b1;
                                    addr_d  = COLS_A;
                                end else begin
                                    y_d = y_q + 5'd1;
                                end
                            end
                            8'h0D: x_d = '0;
                            8'h08: begin
                                if (x_q != '0) begin
                                    x_d     = x_q - 7'd1;
                                    state_d = PUT;
                                    we_d    = 1'b1;
                                    addr_d  = cur_addr - 1'b1;
                                    wdata_d = SPACE;
                                end
                            end
                            8'h0C: begin
                                x_d     = '0;
                                y_d     = '0;
                                state_d = CLR;
                                ptr_d   = '0;
                                we_d    = 1'b1;
                                addr_d  = '0;
                                wdata_d = SPACE;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = SCR_RD;
                    ptr_d   = COLS_A;
                    re_d    = 1'b1;
                    addr_d  = COLS_A;
                end else begin
                    state_d = IDLE;
                end
            end
            SCR_RD: begin
                state_d = SCR_WR;
                we_d    = 1'b1;
                addr_d  = ptr_q - COLS_A;
            end
            SCR_WR: begin
                if (ptr_q == LAST_A) begin
                    state_d = SCR_FILL;
                    ptr_d   = FILL_A;
                    we_d    = 1'b1;
                    addr_d  = FILL_A;
                    wdata_d = SPACE;
                end else begin
                    state_d = SCR_RD;
                    ptr_d   = ptr_q + 1'b1;
                    re_d    = 1'b1;
                    addr_d  = ptr_q + 1'b1;
                end
            end
            SCR_FILL, CLR: begin
                if (ptr_q == LAST_A) begin
                    state_d = IDLE;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ptr_q + 1'b1;
                    wdata_d = SPACE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data only arrives during the SCR_WR cycle itself, so it is
    // forwarded straight to the write port there instead of being re-registered.
    assign char_write_data      = (state_q == SCR_WR) ? r_data_vga_cpu : wdata_q;
    assign char_write_read_addr = addr_q;
    assign char_write_enable    = we_q;
    assign char_read_enable     = re_q;
    assign ch_ready             = (state_q == IDLE);
    assign busy                 = ~ch_ready;
    assign cursor_x             = x_q;
    assign cursor_y             = y_q;

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic [7:0]  rdata;
    logic [6:0]  cx;
    logic [4:0]  cy;
    logic        busy;

    int errors = 0;
    int checks = 0;

    text_console_writer dut (
        .clk                  (clk),
        .reset                (reset),
        .ch_valid             (ch_valid),
        .ch_data              (ch_data),
        .ch_ready             (ch_ready),
        .char_write_read_addr (addr),
        .char_write_data      (wdata),
        .char_write_enable    (we),
        .char_read_enable     (re),
        .r_data_vga_cpu       (rdata),
        .cursor_x             (cx),
        .cursor_y             (cy),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    // Buffer model and bus monitor
    logic [7:0] mem [0:4095];
    logic       preload = 1'b0;
    int         wr_cnt = 0, rd_cnt = 0, both_cnt = 0, seq_cnt = 0;
    int         last_waddr = 0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2400; i++) mem[i] <= 8'(8'h30 + i / 80);
        end else if (we) begin
            mem[addr] <= wdata;
        end
        if (re) rdata <= mem[addr];
        if (we) begin
            wr_cnt <= wr_cnt + 1;
            if (wdata == 8'h20 && int'(addr) == last_waddr + 1) seq_cnt <= seq_cnt + 1;
            last_waddr <= int'(addr);
        end
        if (re) rd_cnt <= rd_cnt + 1;
        if (we && re) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        ch_valid = 1'b0;
        ch_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns at the negedge of the cycle after acceptance (N+1).
    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!ch_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) chk("ready_timeout", 32'(n), 32'd0);
        ch_valid = 1'b1;
        ch_data  = b;
        @(negedge clk);
        ch_valid = 1'b0;
    endtask

    task automatic do_preload();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    initial begin
        int base_w, base_r, base_s, cyc, bad;
        reset = 1'b1;
        ch_valid = 1'b0;
        ch_data = 8'h00;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // Reset state
        do_reset();
        chk("rst_ready", 32'(ch_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_re", 32'(re), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_cx", 32'(cx), 32'd0);
        chk("rst_cy", 32'(cy), 32'd0);

        // Single printable
        send(8'h41);
        chk("p_we", 32'(we), 32'd1);
        chk("p_addr", 32'(addr), 32'd0);
        chk("p_data", 32'(wdata), 32'h41);
        chk("p_cx", 32'(cx), 32'd1);
        chk("p_cy", 32'(cy), 32'd0);
        chk("p_ready_n1", 32'(ch_ready), 32'd0);
        @(negedge clk);
        chk("p_ready_n2", 32'(ch_ready), 32'd1);
        chk("p_we_n2", 32'(we), 32'd0);

        // Column wrap without scroll
        do_reset();
        base_r = rd_cnt;
        for (int i = 0; i < 80; i++) send(8'h42);
        send(8'h43);
        chk("wrap_addr", 32'(addr), 32'd80);
        chk("wrap_data", 32'(wdata), 32'h43);
        chk("wrap_cx", 32'(cx), 32'd1);
        chk("wrap_cy", 32'(cy), 32'd1);
        @(negedge clk);
        chk("wrap_noread", 32'(rd_cnt - base_r), 32'd0);
        chk("wrap_mem79", 32'(mem[79]), 32'h42);

        // Scroll on LF at last row
        do_reset();
        do_preload();
        for (int i = 0; i < 29; i++) send(8'h0A);
        chk("lf_cy29", 32'(cy), 32'd29);
        base_w = wr_cnt;
        base_r = rd_cnt;
        send(8'h0A);
        cyc = 0;
        while (busy && cyc < 6000) begin
            cyc++;
            @(negedge clk);
        end
        chk("scr_cycles", 32'(cyc), 32'd4720);
        chk("scr_mem0", 32'(mem[0]), 32'h31);
        chk("scr_mem2240", 32'(mem[2240]), 32'h4D);
        bad = 0;
        for (int i = 2320; i < 2400; i++) if (mem[i] !== 8'h20) bad++;
        chk("scr_lastrow", 32'(bad), 32'd0);
        chk("scr_writes", 32'(wr_cnt - base_w), 32'd2400);
        chk("scr_reads", 32'(rd_cnt - base_r), 32'd2320);
        chk("scr_both", 32'(both_cnt), 32'd0);
        chk("scr_cx", 32'(cx), 32'd0);
        chk("scr_cy", 32'(cy), 32'd29);

        // Form feed from (17,12)
        do_reset();
        for (int i = 0; i < 12; i++) send(8'h0A);
        for (int i = 0; i < 17; i++) send(8'h61);
        @(negedge clk);
        chk("ff_pre_cx", 32'(cx), 32'd17);
        send(8'h0C);
        chk("ff_first_addr", 32'(addr), 32'd0);
        chk("ff_first_data", 32'(wdata), 32'h20);
        chk("ff_cx", 32'(cx), 32'd0);
        chk("ff_cy", 32'(cy), 32'd0);
        base_w = wr_cnt;
        base_s = seq_cnt;
        cyc = 0;
        while (busy && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
        chk("ff_cycles", 32'(cyc), 32'd2400);
        chk("ff_writes", 32'(wr_cnt - base_w), 32'd2400);
        chk("ff_seq", 32'(seq_cnt - base_s), 32'd2399);
        chk("ff_last_addr", 32'(last_waddr), 32'd2399);

        // Backspace, CR, ignored byte
        do_reset();
        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h78);
        send(8'h08);
        chk("bs_we", 32'(we), 32'd1);
        chk("bs_addr", 32'(addr), 32'd244);
        chk("bs_data", 32'(wdata), 32'h20);
        chk("bs_cx", 32'(cx), 32'd4);
        chk("bs_cy", 32'(cy), 32'd3);
        send(8'h0D);
        chk("cr_cx", 32'(cx), 32'd0);
        chk("cr_ready", 32'(ch_ready), 32'd1);
        chk("cr_we", 32'(we), 32'd0);
        base_w = wr_cnt;
        send(8'h08);
        chk("bs0_we", 32'(we), 32'd0);
        chk("bs0_cx", 32'(cx), 32'd0);
        chk("bs0_cy", 32'(cy), 32'd3);
        chk("bs0_ready", 32'(ch_ready), 32'd1);
        send(8'h01);
        chk("oth_ready", 32'(ch_ready), 32'd1);
        chk("oth_cx", 32'(cx), 32'd0);
        @(negedge clk);
        chk("bs0_oth_nowrite", 32'(wr_cnt - base_w), 32'd0);

        // Reset during scroll
        do_reset();
        do_preload();
        for (int i = 0; i < 30; i++) send(8'h0A);
        repeat (99) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_we", 32'(we), 32'd0);
        chk("mid_re", 32'(re), 32'd0);
        chk("mid_cx", 32'(cx), 32'd0);
        chk("mid_cy", 32'(cy), 32'd0);
        chk("mid_ready", 32'(ch_ready), 32'd1);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
